// File: rtl/up_bus_splitter_pkg.sv
// Shared types and constants for the up register-bus splitter and its request paths.
package up_bus_splitter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } path_state_e;

  localparam logic [31:0] TIMEOUT_DATA_DEF = 32'hDEAD_DEAD;
  localparam int          CNT_WIDTH        = 16;

endpackage

// File: rtl/up_bus_path.sv
// One request path of the splitter: forwards a request to all slaves, then waits for
// the first slave ack (OR-reducing read data of acking slaves) or a bounded timeout.
module up_bus_path
  import up_bus_splitter_pkg::*;
#(
  parameter int          NUM_SLAVES     = 9,
  parameter int          ADDR_WIDTH     = 14,
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [31:0] TIMEOUT_DATA   = TIMEOUT_DATA_DEF,
  parameter bit          DATA_REDUCE    = 1'b1
) (
  input  logic                     up_clk,
  input  logic                     up_rstn,
  input  logic                     req,
  input  logic [ADDR_WIDTH-1:0]    addr,
  input  logic [31:0]              data_in,
  input  logic [NUM_SLAVES-1:0]    ack_in,
  input  logic [32*NUM_SLAVES-1:0] rdata_in,
  output logic                     req_s,
  output logic [ADDR_WIDTH-1:0]    addr_s,
  output logic [31:0]              data_s,
  output logic                     ack,
  output logic [31:0]              rdata,
  output logic                     timeout_evt,
  output logic                     multi_evt,
  output logic                     proto_evt
);

  localparam int            TW         = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  path_state_e             state_q, state_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic                    req_s_q, req_s_d;
  logic [ADDR_WIDTH-1:0]   addr_s_q, addr_s_d;
  logic [31:0]             data_s_q, data_s_d;
  logic                    ack_q, ack_d;
  logic [31:0]             rdata_q, rdata_d;
  logic [31:0]             ack_data;
  logic                    ack_multi;

  // Non-acking slaves are masked so idle slaves may drive anything on their data lanes.
  always_comb begin
    ack_data = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      ack_data = ack_data | (rdata_in[32*i +: 32] & {32{ack_in[i]}});
    end
  end

  assign ack_multi = |(ack_in & (ack_in - NUM_SLAVES'(1)));

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    req_s_d     = 1'b0;
    addr_s_d    = addr_s_q;
    data_s_d    = data_s_q;
    ack_d       = 1'b0;
    rdata_d     = '0;
    timeout_evt = 1'b0;
    multi_evt   = 1'b0;
    proto_evt   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d  = ST_WAIT;
          timer_d  = '0;
          req_s_d  = 1'b1;
          addr_s_d = addr;
          data_s_d = data_in;
        end
      end
      ST_WAIT: begin
        proto_evt = req;
        multi_evt = ack_multi;
        // An ack in the final timer cycle still counts as a normal completion.
        if (|ack_in) begin
          ack_d   = 1'b1;
          rdata_d = DATA_REDUCE ? ack_data : '0;
          state_d = ST_IDLE;
        end else if (timer_q == TIMER_LAST) begin
          ack_d       = 1'b1;
          rdata_d     = DATA_REDUCE ? TIMEOUT_DATA : '0;
          timeout_evt = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      req_s_q  <= 1'b0;
      addr_s_q <= '0;
      data_s_q <= '0;
      ack_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      req_s_q  <= req_s_d;
      addr_s_q <= addr_s_d;
      data_s_q <= data_s_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
    end
  end

  assign req_s  = req_s_q;
  assign addr_s = addr_s_q;
  assign data_s = data_s_q;
  assign ack    = ack_q;
  assign rdata  = rdata_q;

endmodule

// File: rtl/up_bus_splitter.sv
// Register-bus fan-out: independent read and write paths to all slaves, plus shared
// sticky error flags and a saturating timeout counter.
module up_bus_splitter
  import up_bus_splitter_pkg::*;
#(
  parameter int          NUM_SLAVES     = 9,
  parameter int          ADDR_WIDTH     = 14,
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [31:0] TIMEOUT_DATA   = TIMEOUT_DATA_DEF
) (
  input  logic                     up_clk,
  input  logic                     up_rstn,
  input  logic                     up_wreq,
  input  logic [ADDR_WIDTH-1:0]    up_waddr,
  input  logic [31:0]              up_wdata,
  output logic                     up_wack,
  input  logic                     up_rreq,
  input  logic [ADDR_WIDTH-1:0]    up_raddr,
  output logic                     up_rack,
  output logic [31:0]              up_rdata,
  output logic                     up_wreq_s,
  output logic [ADDR_WIDTH-1:0]    up_waddr_s,
  output logic [31:0]              up_wdata_s,
  output logic                     up_rreq_s,
  output logic [ADDR_WIDTH-1:0]    up_raddr_s,
  input  logic [NUM_SLAVES-1:0]    up_wack_in,
  input  logic [NUM_SLAVES-1:0]    up_rack_in,
  input  logic [32*NUM_SLAVES-1:0] up_rdata_in,
  input  logic                     up_err_clr,
  output logic [15:0]              up_timeout_cnt,
  output logic                     up_err_multi,
  output logic                     up_err_proto
);

  logic                 rd_timeout, rd_multi, rd_proto;
  logic                 wr_timeout, wr_multi, wr_proto;
  logic [31:0]          rd_data_s, wr_rdata;
  logic                 unused_sig;
  logic                 err_multi_q, err_multi_d;
  logic                 err_proto_q, err_proto_d;
  logic [CNT_WIDTH-1:0] timeout_cnt_q, timeout_cnt_d;
  logic [CNT_WIDTH-1:0] cnt_base;
  logic [CNT_WIDTH:0]   cnt_sum;

  up_bus_path #(
    .NUM_SLAVES(NUM_SLAVES), .ADDR_WIDTH(ADDR_WIDTH), .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TIMEOUT_DATA(TIMEOUT_DATA), .DATA_REDUCE(1'b1)
  ) u_rd_path (
    .up_clk(up_clk), .up_rstn(up_rstn), .req(up_rreq), .addr(up_raddr), .data_in(32'h0),
    .ack_in(up_rack_in), .rdata_in(up_rdata_in), .req_s(up_rreq_s), .addr_s(up_raddr_s),
    .data_s(rd_data_s), .ack(up_rack), .rdata(up_rdata), .timeout_evt(rd_timeout),
    .multi_evt(rd_multi), .proto_evt(rd_proto)
  );

  up_bus_path #(
    .NUM_SLAVES(NUM_SLAVES), .ADDR_WIDTH(ADDR_WIDTH), .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TIMEOUT_DATA(TIMEOUT_DATA), .DATA_REDUCE(1'b0)
  ) u_wr_path (
    .up_clk(up_clk), .up_rstn(up_rstn), .req(up_wreq), .addr(up_waddr), .data_in(up_wdata),
    .ack_in(up_wack_in), .rdata_in('0), .req_s(up_wreq_s), .addr_s(up_waddr_s),
    .data_s(up_wdata_s), .ack(up_wack), .rdata(wr_rdata), .timeout_evt(wr_timeout),
    .multi_evt(wr_multi), .proto_evt(wr_proto)
  );

  // The read path never carries write data and the write path never returns read data.
  assign unused_sig = ^{rd_data_s, wr_rdata};

  // A new error event in the clearing cycle wins; both paths may time out together (+2).
  always_comb begin
    err_multi_d   = (err_multi_q & ~up_err_clr) | rd_multi | wr_multi;
    err_proto_d   = (err_proto_q & ~up_err_clr) | rd_proto | wr_proto;
    cnt_base      = up_err_clr ? '0 : timeout_cnt_q;
    cnt_sum       = {1'b0, cnt_base} + {{CNT_WIDTH{1'b0}}, rd_timeout}
                    + {{CNT_WIDTH{1'b0}}, wr_timeout};
    timeout_cnt_d = cnt_sum[CNT_WIDTH] ? '1 : cnt_sum[CNT_WIDTH-1:0];
  end

  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      err_multi_q   <= 1'b0;
      err_proto_q   <= 1'b0;
      timeout_cnt_q <= '0;
    end else begin
      err_multi_q   <= err_multi_d;
      err_proto_q   <= err_proto_d;
      timeout_cnt_q <= timeout_cnt_d;
    end
  end

  assign up_err_multi   = err_multi_q;
  assign up_err_proto   = err_proto_q;
  assign up_timeout_cnt = timeout_cnt_q;

endmodule

// File: doc/up_bus_splitter.md
# up_bus_splitter

Register-bus fan-out stage between the AXI-lite-to-up bridge and the per-channel/common register slaves of an ADC core. It forwards each upstream read/write request to every slave and reduces the slave responses to one registered upstream response. It also guarantees a response within a bounded time and flags protocol faults. Read and write paths are independent and may be in flight simultaneously.

## Interface
- NUM_SLAVES, 9, number of downstream slaves (1..16)
- ADDR_WIDTH, 14, register address width
- TIMEOUT_CYCLES, 64, cycles allowed for a slave ack (2..1023)
- TIMEOUT_DATA, 32'hDEAD_DEAD, read data returned on timeout

- up_clk  in  1  register-bus clock
- up_rstn  in  1  asynchronous, active-low reset
- up_wreq / up_rreq  in  1  upstream single-cycle write/read request
- up_waddr / up_raddr  in  ADDR_WIDTH  upstream address
- up_wdata  in  32  upstream write data
- up_wack / up_rack  out  1  upstream single-cycle ack
- up_rdata  out  32  upstream read data, valid with up_rack, else 0
- up_wreq_s / up_rreq_s  out  1  downstream request pulse
- up_waddr_s / up_raddr_s  out  ADDR_WIDTH  downstream address
- up_wdata_s  out  32  downstream write data
- up_wack_in / up_rack_in  in  NUM_SLAVES  per-slave ack
- up_rdata_in  in  32*NUM_SLAVES  per-slave read data, slave n at [32n+31:32n]
- up_err_clr  in  1  clears sticky error flags and counter
- up_timeout_cnt  out  16  saturating count of timed-out transactions
- up_err_multi  out  1  sticky: more than one slave acked in one cycle
- up_err_proto  out  1  sticky: request received while same path busy

## Operation
- Each path (read, write) has FSM IDLE -> WAIT -> IDLE.
- IDLE: on request, register address/data, pulse downstream request next cycle, enter WAIT, clear timer.
- WAIT: timer increments every cycle. Any bit of *_ack_in set -> upstream ack next cycle, read data = OR of all up_rdata_in words of slaves acking that cycle (non-acking slaves masked), return IDLE.
- Timer reaches TIMEOUT_CYCLES without ack -> upstream ack next cycle, read data TIMEOUT_DATA, up_timeout_cnt += 1 (saturates at 16'hFFFF), return IDLE.
- Ack and timeout in same cycle: ack wins, no timeout counted.
- Acks arriving in IDLE (late ack after timeout) are discarded, no upstream ack.
- Request while path in WAIT: ignored, up_err_proto set.
- >1 ack bit in one cycle in WAIT: data OR'd, up_err_multi set.
- Simultaneous read and write requests: both accepted, no ordering between them.
- up_err_clr: flags and counter to 0 next cycle; an error event in the same cycle wins (flag set, counter = 1).
- Downstream address/data hold last accepted value between requests.

## Timing
- Reset: all outputs 0, FSMs IDLE, timers 0.
- Reset mid-transaction: transaction abandoned, no ack emitted after release.
- Request sampled cycle 0 -> downstream pulse cycle 1.
- Slave ack sampled cycle k (k>=1) -> upstream ack cycle k+1.
- No ack sampled in cycles 1..TIMEOUT_CYCLES -> timeout ack cycle TIMEOUT_CYCLES+1.
- Minimum turnaround: next request accepted in the cycle the upstream ack is driven.
- All outputs registered; no combinational path input to output.

## Structure
- Shared package: path state enum (IDLE, WAIT), TIMEOUT_DATA default, counter width constant.
- One sub-module up_bus_path instantiated twice (read with data reduction enabled, write with it disabled); top holds the shared error flags and timeout counter (sum of both timeout events per cycle, +2 possible).

## Test plan
- Read addr 0x0010, slave 3 acks cycle 2 with 0x1234_5678 -> up_rack cycle 3, up_rdata 0x1234_5678, downstream pulse exactly cycle 1.
- Read with no ack, TIMEOUT_CYCLES=64 -> up_rack cycle 65, up_rdata 0xDEAD_DEAD, up_timeout_cnt 1; late ack cycle 70 ignored.
- Slaves 0 and 8 ack together with 0x00F0 and 0x0F00 -> up_rdata 0x0FF0, up_err_multi 1; up_err_clr -> 0.
- Write and read requested same cycle, acks at cycles 4 and 2 -> up_wack cycle 5, up_rack cycle 3, independent.
- Second up_rreq in WAIT -> no second downstream pulse, up_err_proto 1.
- up_rstn low during WAIT -> all outputs 0; after release no ack; next read completes normally.
